// File: rtl/core_pkg.sv
// Shared register-file constants and the write-back request record used by
// the result arbiter.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREG  = 32;

    typedef struct packed {
        logic             fmode;
        logic [REG_W-1:0] regidx;
        logic [XLEN-1:0]  data;
    } wb_req_t;

    // greg 0 is hardwired to zero, so writes to it and pending marks on it are dropped
    function automatic logic is_greg0(input logic fmode, input logic [REG_W-1:0] r);
        return !fmode && (r == '0);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of result-source handshakes, register-file write port and
// scoreboard issue/query signals around the write-back arbiter.
interface wb_arbiter_if import core_pkg::*; #(
    parameter int N_SRC = 3
) ();

    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC-1:0]       src_ready;
    logic [N_SRC-1:0]       src_fmode;
    logic [N_SRC*REG_W-1:0] src_reg;
    logic [N_SRC*XLEN-1:0]  src_data;

    logic                   wenable;
    logic                   wfmode;
    logic [REG_W-1:0]       wreg;
    logic [XLEN-1:0]        wdata;

    logic                   iss_valid;
    logic                   iss_fmode;
    logic [REG_W-1:0]       iss_reg;

    logic                   q_fmode;
    logic [REG_W-1:0]       q_reg1;
    logic [REG_W-1:0]       q_reg2;
    logic                   q_busy1;
    logic                   q_busy2;

    modport slave (
        input  src_valid, src_fmode, src_reg, src_data,
        input  iss_valid, iss_fmode, iss_reg,
        input  q_fmode, q_reg1, q_reg2,
        output src_ready, wenable, wfmode, wreg, wdata,
        output q_busy1, q_busy2
    );

    modport master (
        output src_valid, src_fmode, src_reg, src_data,
        output iss_valid, iss_fmode, iss_reg,
        output q_fmode, q_reg1, q_reg2,
        input  src_ready, wenable, wfmode, wreg, wdata,
        input  q_busy1, q_busy2
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N, returned as a one-hot grant.
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin collects one execution-unit result per cycle,
// drives the registered register-file write port and tracks pending writes.
module wb_arbiter import core_pkg::*; #(
    parameter int N_SRC = 3
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  grant;
    logic              hs;
    logic [PTR_W-1:0]  gidx;
    wb_req_t           sel;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wen_q, wen_d;
    wb_req_t           wr_q, wr_d;
    logic [2*NREG-1:0] pend_q, pend_d;
    logic              busy1_q, busy1_d;
    logic              busy2_q, busy2_d;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req   (bus.src_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        sel  = '0;
        gidx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                gidx       = PTR_W'(i);
                sel.fmode  = bus.src_fmode[i];
                sel.regidx = bus.src_reg[i*REG_W +: REG_W];
                sel.data   = bus.src_data[i*XLEN +: XLEN];
            end
        end
        hs = |grant;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (gidx == PTR_W'(N_SRC - 1)) ? '0 : gidx + PTR_W'(1);
        end
        wen_d = hs && !is_greg0(sel.fmode, sel.regidx);
        wr_d  = hs ? sel : wr_q;

        // Clear before set so an issue landing on the retiring index stays pending
        pend_d = pend_q;
        if (hs) begin
            pend_d[{sel.fmode, sel.regidx}] = 1'b0;
        end
        if (bus.iss_valid && !is_greg0(bus.iss_fmode, bus.iss_reg)) begin
            pend_d[{bus.iss_fmode, bus.iss_reg}] = 1'b1;
        end
        busy1_d = pend_d[{bus.q_fmode, bus.q_reg1}];
        busy2_d = pend_d[{bus.q_fmode, bus.q_reg2}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            wr_q     <= '0;
            pend_q   <= '0;
            busy1_q  <= 1'b0;
            busy2_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            wr_q     <= wr_d;
            pend_q   <= pend_d;
            busy1_q  <= busy1_d;
            busy2_q  <= busy2_d;
        end
    end

    assign bus.src_ready = grant;
    assign bus.wenable   = wen_q;
    assign bus.wfmode    = wr_q.fmode;
    assign bus.wreg      = wr_q.regidx;
    assign bus.wdata     = wr_q.data;
    assign bus.q_busy1   = busy1_q;
    assign bus.q_busy2   = busy2_q;

endmodule
